jtag_loader: RTL and testbench
==============================

JTAG_LOADER -- requirements
Module: jtag_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 512, giving the depth of each memory image in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Jen, input, 1 bit: load enable; while high, one word is accepted per cycle.
REQ-005 The block SHALL have port Jin, input, 32 bits: serial load word.
REQ-006 The block SHALL have port Jout, output, 32 bits: readback word (REQ-016, REQ-024).
REQ-007 The block SHALL have ports dmem_we (1 bit), dmem_addr (9 bits) and dmem_wdata (32 bits), all outputs: the data-memory write port.
REQ-008 The block SHALL have ports imem_we (1 bit), imem_addr (9 bits) and imem_wdata (32 bits), all outputs: the instruction-memory write port.
REQ-009 The block SHALL have port core_halt, output, 1 bit: holds both cores in reset until the image is loaded.
REQ-010 The block SHALL have port load_done, output, 1 bit: image complete.

Function
REQ-011 The block SHALL implement states LOAD_D, LOAD_I and DONE; reset SHALL enter LOAD_D.
REQ-012 A 10-bit word counter cnt SHALL increment by 1 on each rising edge with Jen=1 in LOAD_D or LOAD_I, and SHALL hold when Jen=0 (pause, no write).
REQ-013 In LOAD_D with Jen=1, the block SHALL register dmem_we=1, dmem_addr=511-cnt[8:0] and dmem_wdata=Jin, presented the cycle after sampling (1-cycle latency).
REQ-014 In LOAD_I with Jen=1, the block SHALL register imem_we=1, imem_addr=511-cnt[8:0] and imem_wdata=Jin, also with 1-cycle latency.
REQ-015 State transitions:
- LOAD_D SHALL go to LOAD_I on the edge that accepts word 511 (cnt 511->512).
- LOAD_I SHALL go to DONE on the edge that accepts word 1023 (cnt 1023->0 wrap).
- DONE SHALL be terminal until rst.
REQ-016 Jout SHALL equal the last word accepted, registered (1-cycle delay), and SHALL hold its value when no word is accepted.
REQ-017 dmem_we and imem_we SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted word.
REQ-018 In DONE, Jen=1 SHALL be ignored: no writes, cnt held, Jout unchanged.
REQ-019 load_done SHALL rise the cycle after the final imem write is presented, and core_halt SHALL fall on the same edge.
REQ-020 Jen toggling mid-image SHALL NOT skip or duplicate any address.

Reset
REQ-021 Asserting rst at any time, including mid-load, SHALL immediately clear: cnt=0, state=LOAD_D, all we=0, all addr/wdata=0, Jout=0, load_done=0, core_halt=1; an in-flight registered write SHALL be dropped.
REQ-022 After rst deasserts, the next accepted word SHALL go to dmem_addr 511.

Configuration
REQ-023 With macro JLOAD_CHECKSUM_EN defined, the block SHALL accumulate a mod-2^32 sum of all 1024 accepted words, cleared by rst.
REQ-024 With JLOAD_CHECKSUM_EN defined, in DONE with Jen=0, Jout SHALL show the checksum; without the macro, Jout SHALL always follow REQ-016 and no checksum logic SHALL exist.

Verification
REQ-025 Full image test: apply rst for 4 cycles, then 1024 words Jin=k for k=0..1023 with Jen=1.
- Required: dmem[511-k]=k for k<512.
- Required: imem[511-(k-512)]=k for k>=512.
- Required: load_done=1 and core_halt=0 one cycle after the last write.
REQ-026 Pause test: Jen=0 for 5 cycles after word 100.
- Required: no we pulse during the pause.
- Required: word 101 goes to dmem_addr 410.
REQ-027 Boundary test: at word 511 -> dmem_addr 0, dmem_we; word 512 -> imem_addr 511, imem_we; never both high in one cycle.
REQ-028 Reset mid-load test: rst at word 700.
- Required: outputs cleared asynchronously.
- Required: the next word goes to dmem_addr 511, with load_done=0.
REQ-029 Post-done test: extra 10 words with Jen=1 -> no we pulse; Jout unchanged.
REQ-030 Checksum test: with JLOAD_CHECKSUM_EN and Jin=k for all words, Jout SHALL equal 523776 (0x0007FE00) in DONE with Jen=0.

Source files
------------

// File: rtl/jtag_loader.sv
// jtag_loader -- streams a two-part memory image into the data and instruction
// memories, one 32-bit word per enabled cycle, and holds the cores in reset
// until the whole image has arrived.
//
// The first WORDS words go to data memory and the next WORDS words go to
// instruction memory. Each part is written top-down: the first word of a part
// lands at address WORDS-1 and the last word lands at address 0.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   Jen         in   load enable, one word accepted per cycle while high
//   Jin[31:0]   in   load word
//   Jout[31:0]  out  last accepted word, registered (checksum in DONE, see below)
//   dmem_we/dmem_addr[8:0]/dmem_wdata[31:0]  out  data-memory write port
//   imem_we/imem_addr[8:0]/imem_wdata[31:0]  out  instruction-memory write port
//   core_halt   out  high until the image is loaded
//   load_done   out  image complete
//
// Optional feature (macro JLOAD_CHECKSUM_EN): keeps a mod-2^32 sum of every
// accepted word. Once in DONE with Jen low, Jout shows that sum instead of
// the last word. With the macro undefined, no checksum logic is built.
module jtag_loader #(
   parameter int WORDS = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Jen,
   input  logic [31:0] Jin,
   output logic [31:0] Jout,
   output logic        dmem_we,
   output logic [8:0]  dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        imem_we,
   output logic [8:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_halt,
   output logic        load_done
);

   typedef enum logic [1:0] {
      LOAD_D = 2'd0,
      LOAD_I = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Counter values at which the last word of each image part is accepted.
   localparam logic [9:0] LAST_D = 10'(WORDS - 1);
   localparam logic [9:0] LAST_I = 10'(2 * WORDS - 1);
   localparam logic [8:0] TOP    = 9'(WORDS - 1);

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        dmem_we_q, dmem_we_d;
   logic [8:0]  dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        imem_we_q, imem_we_d;
   logic [8:0]  imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic [31:0] jout_q, jout_d;
   logic        load_done_q, load_done_d;
   logic        accept;

`ifdef JLOAD_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
`endif

   // Words offered while in DONE are ignored entirely.
   assign accept = Jen && (state_q != DONE);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      jout_d       = jout_q;
      // DONE is entered on the edge that accepts the last word; that word's
      // imem write is presented for one cycle, and load_done follows one
      // edge later.
      load_done_d  = load_done_q | (state_q == DONE);

      if (accept) begin
         cnt_d  = cnt_q + 10'd1;
         jout_d = Jin;
         if (state_q == LOAD_D) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = TOP - cnt_q[8:0];
            dmem_wdata_d = Jin;
            if (cnt_q == LAST_D) state_d = LOAD_I;
         end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = TOP - cnt_q[8:0];
            imem_wdata_d = Jin;
            if (cnt_q == LAST_I) begin
               state_d = DONE;
               cnt_d   = 10'd0;
            end
         end
      end
   end

`ifdef JLOAD_CHECKSUM_EN
   always_comb begin
      sum_d = sum_q;
      if (accept) sum_d = sum_q + Jin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sum_q <= 32'd0;
      else     sum_q <= sum_d;
   end

   assign Jout = (state_q == DONE && !Jen) ? sum_q : jout_q;
`else
   assign Jout = jout_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LOAD_D;
         cnt_q        <= 10'd0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 9'd0;
         dmem_wdata_q <= 32'd0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= 9'd0;
         imem_wdata_q <= 32'd0;
         jout_q       <= 32'd0;
         load_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         jout_q       <= jout_d;
         load_done_q  <= load_done_d;
      end
   end

   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign load_done  = load_done_q;
   // Cores are released on the same edge that load_done rises.
   assign core_halt  = ~load_done_q;

endmodule

// File: tb/tb_jtag_loader.sv
// Directed bench for jtag_loader: reset, a full image with a pause after
// word 100 and the data/instruction boundary, post-done behaviour, and an
// asynchronous reset in the middle of a load.
module tb_jtag_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Jen = 1'b0;
   logic [31:0] Jin = 32'd0;
   logic [31:0] Jout;
   logic        dmem_we, imem_we, core_halt, load_done;
   logic [8:0]  dmem_addr, imem_addr;
   logic [31:0] dmem_wdata, imem_wdata;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   jtag_loader #(.WORDS(512)) dut (
      .clk(clk), .rst(rst), .Jen(Jen), .Jin(Jin), .Jout(Jout),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_halt(core_halt), .load_done(load_done)
   );

   // Advance one cycle; inputs are changed and outputs sampled 1 ns after
   // the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; Jen = 1'b0; Jin = 32'd0;
      repeat (4) step();
      checks++;
      if ({dmem_we, imem_we, dmem_addr, imem_addr, dmem_wdata, imem_wdata, Jout,
           load_done, core_halt} !== {1'b0, 1'b0, 9'd0, 9'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1})
         $display("FAIL reset_state: we=%b/%b addr=%0d/%0d Jout=%h done=%b halt=%b, required all zero, halt=1",
                  dmem_we, imem_we, dmem_addr, imem_addr, Jout, load_done, core_halt);
      else passes++;
      rst = 1'b0;
      step();
   endtask

   // Full image Jin=k, k=0..1023, with Jen low for 5 cycles after word 100.
   task automatic test_full_image();
      logic [8:0] ea;
      for (int k = 0; k < 1024; k++) begin
         Jin = 32'(k); Jen = 1'b1;
         step();
         checks++;
         if (k < 512) begin
            ea = 9'(511 - k);
            if (dmem_we !== 1'b1 || imem_we !== 1'b0 || dmem_addr !== ea || dmem_wdata !== 32'(k) || Jout !== 32'(k))
               $display("FAIL dmem_word_%0d: we=%b/%b addr=%0d data=%0d Jout=%0d, required we=1/0 addr=%0d data=%0d",
                        k, dmem_we, imem_we, dmem_addr, dmem_wdata, Jout, ea, k);
            else passes++;
         end else begin
            ea = 9'(511 - (k - 512));
            if (imem_we !== 1'b1 || dmem_we !== 1'b0 || imem_addr !== ea || imem_wdata !== 32'(k) || Jout !== 32'(k))
               $display("FAIL imem_word_%0d: we=%b/%b addr=%0d data=%0d Jout=%0d, required we=0/1 addr=%0d data=%0d",
                        k, dmem_we, imem_we, imem_addr, imem_wdata, Jout, ea, k);
            else passes++;
         end
         if (k == 101) begin
            checks++;
            if (dmem_addr !== 9'd410) $display("FAIL pause_resume_addr: got %0d required 410", dmem_addr);
            else passes++;
         end
         if (k == 511) begin
            checks++;
            if (dmem_addr !== 9'd0 || dmem_we !== 1'b1 || imem_we !== 1'b0)
               $display("FAIL boundary_511: addr=%0d we=%b/%b required addr=0 we=1/0", dmem_addr, dmem_we, imem_we);
            else passes++;
         end
         if (k == 512) begin
            checks++;
            if (imem_addr !== 9'd511 || imem_we !== 1'b1 || dmem_we !== 1'b0)
               $display("FAIL boundary_512: addr=%0d we=%b/%b required addr=511 we=0/1", imem_addr, dmem_we, imem_we);
            else passes++;
         end
         if (k == 1023) begin
            checks++;
            if (load_done !== 1'b0 || core_halt !== 1'b1)
               $display("FAIL done_early: done=%b halt=%b required 0/1 while final write presented", load_done, core_halt);
            else passes++;
         end
         if (k == 100) begin
            Jen = 1'b0;
            for (int p = 0; p < 5; p++) begin
               step();
               checks++;
               if (dmem_we !== 1'b0 || imem_we !== 1'b0 || Jout !== 32'd100)
                  $display("FAIL pause_cycle_%0d: we=%b/%b Jout=%0d required 0/0 and 100", p, dmem_we, imem_we, Jout);
               else passes++;
            end
         end
      end
      Jen = 1'b0;
      step();
      checks++;
      if (load_done !== 1'b1 || core_halt !== 1'b0 || imem_we !== 1'b0 || dmem_we !== 1'b0)
         $display("FAIL load_done: done=%b halt=%b we=%b/%b required 1/0 and no write",
                  load_done, core_halt, dmem_we, imem_we);
      else passes++;
   endtask

   task automatic test_post_done();
      for (int i = 0; i < 10; i++) begin
         Jin = 32'hDEAD_0000 + 32'(i); Jen = 1'b1;
         step();
         checks++;
         if (dmem_we !== 1'b0 || imem_we !== 1'b0 || Jout !== 32'd1023 || load_done !== 1'b1)
            $display("FAIL post_done_%0d: we=%b/%b Jout=%0d done=%b required 0/0 1023 1",
                     i, dmem_we, imem_we, Jout, load_done);
         else passes++;
      end
      Jen = 1'b0;
      step();
      checks++;
`ifdef JLOAD_CHECKSUM_EN
      if (Jout !== 32'd523776) $display("FAIL checksum: Jout=%0d required 523776", Jout);
      else passes++;
`else
      if (Jout !== 32'd1023) $display("FAIL done_jout: Jout=%0d required 1023", Jout);
      else passes++;
`endif
   endtask

   task automatic test_reset_mid_load();
      rst = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      step();
      for (int k = 0; k <= 700; k++) begin
         Jin = 32'(k); Jen = 1'b1;
         step();
      end
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 9'd323)
         $display("FAIL word_700: imem_we=%b addr=%0d required 1 and 323", imem_we, imem_addr);
      else passes++;
      // Assert reset between edges; outputs must clear with no clock edge.
      Jen = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dmem_we, imem_we, dmem_addr, imem_addr, dmem_wdata, imem_wdata, Jout,
           load_done, core_halt} !== {1'b0, 1'b0, 9'd0, 9'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1})
         $display("FAIL async_reset: we=%b/%b addr=%0d/%0d Jout=%h done=%b halt=%b, required cleared",
                  dmem_we, imem_we, dmem_addr, imem_addr, Jout, load_done, core_halt);
      else passes++;
      step();
      step();
      rst = 1'b0;
      Jin = 32'h0000_ABCD; Jen = 1'b1;
      step();
      checks++;
      if (dmem_we !== 1'b1 || imem_we !== 1'b0 || dmem_addr !== 9'd511 || dmem_wdata !== 32'h0000_ABCD || load_done !== 1'b0)
         $display("FAIL after_reset_word: we=%b/%b addr=%0d data=%h done=%b required 1/0 511 0000abcd 0",
                  dmem_we, imem_we, dmem_addr, dmem_wdata, load_done);
      else passes++;
      Jen = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_full_image();
      test_post_done();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
